// File: rtl/line_data_memory.sv
// Line-granular backing memory serving whole-line reads and write-backs from the cache.
// Latency: LATENCY cycles from acceptance to completion; read data pulses is_output_valid for one cycle.
// Backpressure: mem_ready is low for exactly LATENCY cycles per accepted request; requests while busy are ignored.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   is_input_valid    request present; accepted with mem_ready and exactly one of mem_read/mem_write
//   addr              word address of any word in the target line (offset and upper bits ignored)
//   mem_read/write    operation select; both or neither set drops the request
//   din               write line data, word 0 in din[31:0]
//   is_output_valid   one-cycle read-response pulse
//   dout              last completed read line (writes never change it)
//   mem_ready         registered, high when idle
// Optional macro LINE_DATA_MEMORY_STATS_EN adds rd_count/wr_count completion counters.
module line_data_memory #(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_LINES  = 256,
  parameter int LATENCY    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
`ifdef LINE_DATA_MEMORY_STATS_EN
  ,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count
`endif
);

  localparam int LW = BLOCK_SIZE * 8;
  localparam int WO = $clog2(BLOCK_SIZE / 4);
  localparam int IW = $clog2(NUM_LINES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            op_read_q;
  logic [IW-1:0]   idx_q;
  logic [LW-1:0]   din_q;
  logic [LW-1:0]   mem [NUM_LINES];
  logic            accept;
  logic            complete;

  // Only the index field of addr selects a line; the rest is deliberately ignored.
  logic            addr_unused;
  assign addr_unused = ^addr;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A malformed op (read and write equal) never leaves IDLE.
        if (is_input_valid && (mem_read ^ mem_write)) begin
          accept  = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      mem_ready       <= 1'b1;
      is_output_valid <= 1'b0;
      dout            <= '0;
      op_read_q       <= 1'b0;
      idx_q           <= '0;
      din_q           <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      // Registered copy of "idle next cycle", so the response cycle also shows ready.
      mem_ready       <= (state_d == S_IDLE);
      is_output_valid <= complete && op_read_q;
      if (accept) begin
        cnt_q     <= CW'(LATENCY - 1);
        op_read_q <= mem_read;
        idx_q     <= addr[WO +: IW];
        din_q     <= din;
      end else if ((state_q == S_BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (complete) begin
        if (op_read_q) begin
          dout <= mem[idx_q];
        end else begin
          mem[idx_q] <= din_q;
        end
      end
    end
  end

`ifdef LINE_DATA_MEMORY_STATS_EN
  // Counted at completion, so an operation aborted by reset is never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (complete) begin
      if (op_read_q) begin
        rd_count <= rd_count + 32'd1;
      end else begin
        wr_count <= wr_count + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule
